// File: rtl/pong_input_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : pong_input_pkg
// | Description : Shared constants and width helper for the button input bank.
// |               SYNC_STAGES - depth of the per-channel metastability chain.
// |               clog2_max   - bits needed to hold max(a, b) inclusive.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
package pong_input_pkg;

  localparam int SYNC_STAGES = 2;

  // Width of a counter that must be able to reach max(a, b).
  function automatic int clog2_max(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : debounce_channel
// | Description : One debounced button: synchroniser, run-length stability
// |               counter, registered press/release strobes and an optional
// |               auto-repeat strobe while the button is held.
// | Ports       : clk           - system clock
// |               reset         - synchronous, active-high reset
// |               button        - raw asynchronous button level
// |               debounced     - filtered level
// |               pressed       - one-cycle strobe on 0->1 of debounced
// |               released      - one-cycle strobe on 1->0 of debounced
// |               repeat_strobe - one-cycle auto-repeat strobe while held
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module debounce_channel
  import pong_input_pkg::*;
#(
  parameter int STABLE_CYCLES = 8,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic debounced,
  output logic pressed,
  output logic released,
  output logic repeat_strobe
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   debounced_q, debounced_d;
  logic                   pressed_q, pressed_d;
  logic                   released_q, released_d;
  logic                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Any cycle that agrees with the current output restarts the run, so
  // disagreement has to be uninterrupted for STABLE_CYCLES cycles.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], button};
    cnt_d       = cnt_q;
    debounced_d = debounced_q;
    pressed_d   = 1'b0;
    released_d  = 1'b0;
    if (sync_s == debounced_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      debounced_d = sync_s;
      cnt_d       = '0;
      pressed_d   = sync_s;
      released_d  = ~sync_s;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      debounced_q <= 1'b0;
      pressed_q   <= 1'b0;
      released_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      debounced_q <= debounced_d;
      pressed_q   <= pressed_d;
      released_q  <= released_d;
    end
  end

  assign debounced = debounced_q;
  assign pressed   = pressed_q;
  assign released  = released_q;

  generate
    if (REPEAT_DELAY > 0) begin : g_repeat
      localparam int HOLD_W = clog2_max(REPEAT_DELAY, REPEAT_PERIOD);

      logic [HOLD_W-1:0] hcnt_q, hcnt_d, hcnt_inc, hold_target;
      logic              phase_q, phase_d;   // 0: waiting for first repeat
      logic              repeat_q, repeat_d;

      // The counter restarts from zero after every strobe; the phase bit
      // selects whether the next target is the initial delay or the period.
      // It only runs when held both before and after this edge, so the press
      // edge clears it and the release edge never emits a strobe.
      always_comb begin
        hcnt_inc    = hcnt_q + HOLD_W'(1);
        hold_target = phase_q ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(REPEAT_DELAY);
        hcnt_d      = '0;
        phase_d     = 1'b0;
        repeat_d    = 1'b0;
        if (debounced_q && debounced_d) begin
          phase_d = phase_q;
          if (hcnt_inc == hold_target) begin
            hcnt_d   = '0;
            phase_d  = 1'b1;
            repeat_d = 1'b1;
          end else begin
            hcnt_d = hcnt_inc;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          hcnt_q   <= '0;
          phase_q  <= 1'b0;
          repeat_q <= 1'b0;
        end else begin
          hcnt_q   <= hcnt_d;
          phase_q  <= phase_d;
          repeat_q <= repeat_d;
        end
      end

      assign repeat_strobe = repeat_q;
    end else begin : g_no_repeat
      assign repeat_strobe = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : debounce_bank
// | Description : Bank of CHANNELS independent button debouncers.
// | Ports       : clk           - system clock
// |               reset         - synchronous, active-high reset
// |               buttons       - raw asynchronous levels, bit i = channel i
// |               debounced     - filtered level per channel
// |               pressed       - one-cycle 0->1 strobe per channel
// |               released      - one-cycle 1->0 strobe per channel
// |               repeat_strobe - one-cycle auto-repeat strobe per channel
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module debounce_bank
  import pong_input_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] buttons,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released,
  output logic [CHANNELS-1:0] repeat_strobe
);

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
      debounce_channel #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_channel (
        .clk           (clk),
        .reset         (reset),
        .button        (buttons[i]),
        .debounced     (debounced[i]),
        .pressed       (pressed[i]),
        .released      (released[i]),
        .repeat_strobe (repeat_strobe[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : tb_debounce_bank
// | Description : Directed self-checking bench for debounce_bank with
// |               CHANNELS=4, STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module tb_debounce_bank;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] buttons = 4'b0000;
  logic [3:0] debounced;
  logic [3:0] pressed;
  logic [3:0] released;
  logic [3:0] repeat_strobe;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .CHANNELS      (4),
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .buttons       (buttons),
    .debounced     (debounced),
    .pressed       (pressed),
    .released      (released),
    .repeat_strobe (repeat_strobe)
  );

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns later.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       bnc [5];
    logic [3:0] exp_rep;
    bnc = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset with all buttons held
    buttons = 4'b1111;
    reset   = 1'b1;
    step(3);
    chk("rst_debounced", debounced, 4'b0000);
    chk("rst_pressed", pressed, 4'b0000);
    chk("rst_released", released, 4'b0000);
    chk("rst_repeat", repeat_strobe, 4'b0000);
    reset = 1'b0;
    step(5);
    chk("held_rst_edge5_deb", debounced, 4'b0000);
    chk("held_rst_edge5_prs", pressed, 4'b0000);
    step(1);
    chk("held_rst_edge6_deb", debounced, 4'b1111);
    chk("held_rst_edge6_prs", pressed, 4'b1111);
    chk("held_rst_edge6_rel", released, 4'b0000);
    step(1);
    chk("held_rst_edge7_prs", pressed, 4'b0000);
    chk("held_rst_edge7_deb", debounced, 4'b1111);
    buttons = 4'b0000;
    step(5);
    chk("all_rel_edge5_deb", debounced, 4'b1111);
    step(1);
    chk("all_rel_edge6_rel", released, 4'b1111);
    chk("all_rel_edge6_deb", debounced, 4'b0000);
    chk("all_rel_edge6_prs", pressed, 4'b0000);
    step(1);
    chk("all_rel_edge7_rel", released, 4'b0000);

    // ch0 bounce then stable high
    for (int i = 0; i < 5; i++) begin
      buttons[0] = bnc[i];
      step(1);
      chk("bounce_deb", debounced, 4'b0000);
    end
    buttons[0] = 1'b1;
    step(5);
    chk("bounce_edge5_deb", debounced, 4'b0000);
    chk("bounce_edge5_prs", pressed, 4'b0000);
    step(1);
    chk("bounce_edge6_deb", debounced, 4'b0001);
    chk("bounce_edge6_prs", pressed, 4'b0001);
    step(1);
    chk("bounce_edge7_prs", pressed, 4'b0000);
    buttons = 4'b0000;
    step(6);
    chk("ch0_rel", released, 4'b0001);
    step(1);

    // ch1 short low glitch, then a real release
    buttons = 4'b0010;
    step(6);
    chk("ch1_press", pressed, 4'b0010);
    step(1);
    buttons = 4'b0000;
    step(3);
    buttons = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch_deb", debounced, 4'b0010);
      chk("glitch_rel", released, 4'b0000);
    end
    buttons = 4'b0000;
    step(5);
    chk("ch1_rel_edge5_deb", debounced, 4'b0010);
    step(1);
    chk("ch1_rel_edge6_rel", released, 4'b0010);
    chk("ch1_rel_edge6_deb", debounced, 4'b0000);
    step(1);
    chk("ch1_rel_edge7_rel", released, 4'b0000);

    // ch2 auto-repeat; release lands on what would be the +40 strobe
    buttons = 4'b0100;
    step(6);
    chk("ch2_press", pressed, 4'b0100);
    for (int k = 1; k <= 40; k++) begin
      step(1);
      exp_rep = (k >= 20 && k < 40 && (k % 5) == 0) ? 4'b0100 : 4'b0000;
      chk("repeat", repeat_strobe, exp_rep);
      if (k < 40) chk("repeat_no_rel", released, 4'b0000);
      if (k == 34) buttons = 4'b0000;
    end
    chk("repeat_rel_cycle_rel", released, 4'b0100);
    chk("repeat_rel_cycle_deb", debounced, 4'b0000);
    step(1);
    chk("repeat_after_rel", repeat_strobe, 4'b0000);
    step(5);
    chk("repeat_idle", repeat_strobe, 4'b0000);

    // ch0 and ch3 together
    buttons = 4'b1001;
    step(5);
    chk("dual_edge5_prs", pressed, 4'b0000);
    step(1);
    chk("dual_edge6_prs", pressed, 4'b1001);
    chk("dual_edge6_deb", debounced, 4'b1001);
    step(1);
    chk("dual_edge7_prs", pressed, 4'b0000);
    buttons = 4'b0000;
    step(6);
    chk("dual_rel", released, 4'b1001);
    step(2);

    // reset mid-count (cnt = 2 of 4)
    buttons = 4'b0001;
    step(4);
    reset = 1'b1;
    step(1);
    chk("midcnt_rst_deb", debounced, 4'b0000);
    chk("midcnt_rst_prs", pressed, 4'b0000);
    reset = 1'b0;
    step(5);
    chk("midcnt_edge5_deb", debounced, 4'b0000);
    step(1);
    chk("midcnt_edge6_deb", debounced, 4'b0001);
    chk("midcnt_edge6_prs", pressed, 4'b0001);

    // reset while debounced is high, button kept held
    step(2);
    reset = 1'b1;
    step(1);
    chk("hi_rst_deb", debounced, 4'b0000);
    reset = 1'b0;
    step(5);
    chk("hi_rst_edge5_deb", debounced, 4'b0000);
    step(1);
    chk("hi_rst_edge6_prs", pressed, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
